// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search helper for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       found;
  } pick_t;

  // Rotate the request mask so the pointer lands on bit 0, take the lowest set
  // bit, then map that position back to a requester index modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t              r;
    logic [MAX_REQ-1:0] rot;
    r   = '0;
    rot = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) rot[3'(i)] = mask[3'((i + int'(ptr)) % n)];
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (rot[3'(i)]) begin
        r.found = 1'b1;
        r.idx   = 3'((i + int'(ptr)) % n);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_priority_picker #(
  parameter  int NUM_REQ = 4,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [GW-1:0]      idx_o,
  output logic               found_o
);
  import uart_arb_pkg::*;

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(mask_i), 3'(ptr_i), NUM_REQ);
    idx_o   = GW'(pick.idx);
    found_o = pick.found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional idle-hold release timer: define UART_ARB_HOLD_TIMEOUT_EN.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter  int NUM_REQ      = 4,
  parameter  int HOLD_TIMEOUT = 65535,
  localparam int GW           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      uart_tx_req,
  output logic [BYTE_W-1:0]         uart_tx_data,
  input  logic                      uart_tx_ready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      released_by_timeout
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || HOLD_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and HOLD_TIMEOUT >= 1");
  end

  state_t              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d, grant_q, grant_d;
  logic [GW-1:0]       pick_idx, sel_idx, ptr_next;
  logic                pick_found, capture, sel_last;
  logic                lock_q, lock_d, txreq_q, txreq_d, busy_q, busy_d;
  logic [BYTE_W-1:0]   data_q, data_d, sel_data;
  logic [NUM_REQ-1:0]  ack_q, ack_d;

`ifdef UART_ARB_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .mask_i  (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // IDLE arbitrates over everyone; HOLD only listens to the locked owner.
  assign sel_idx  = (state_q == HOLD) ? grant_q : pick_idx;
  assign sel_data = req_data[int'(sel_idx)*BYTE_W +: BYTE_W];
  assign sel_last = req_last[sel_idx];
  assign capture  = ((state_q == IDLE) && pick_found) ||
                    ((state_q == HOLD) && req_valid[grant_q]);
  assign ptr_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    data_d  = data_q;
    txreq_d = 1'b0;
    ack_d   = '0;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    if (capture) begin
      grant_d        = sel_idx;
      data_d         = sel_data;
      lock_d         = ~sel_last;
      txreq_d        = 1'b1;
      ack_d[sel_idx] = 1'b1;
      state_d        = WAIT;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (uart_tx_ready) begin
            if (lock_q) begin
              state_d = HOLD;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end else begin
              ptr_d   = ptr_next;
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
`ifdef UART_ARB_HOLD_TIMEOUT_EN
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
            lock_d  = 1'b0;
            ptr_d   = ptr_next;
            state_d = IDLE;
            tmo_d   = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      data_q  <= '0;
      txreq_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      txreq_q <= txreq_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_ARB_HOLD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign released_by_timeout = tmo_q;
`else
  assign released_by_timeout = 1'b0;
`endif

  assign req_ack      = ack_q;
  assign uart_tx_req  = txreq_q;
  assign uart_tx_data = data_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner-case sequences, randomized packet streams.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_last, req_ack;
  logic [8*N-1:0]   req_data;
  logic             uart_tx_req, uart_tx_ready, busy, released_by_timeout;
  logic [7:0]       uart_tx_data;
  logic [1:0]       grant_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_last            (req_last),
    .req_ack             (req_ack),
    .uart_tx_req         (uart_tx_req),
    .uart_tx_data        (uart_tx_data),
    .uart_tx_ready       (uart_tx_ready),
    .grant_id            (grant_id),
    .busy                (busy),
    .released_by_timeout (released_by_timeout)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_g;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t        tbl[8];
  logic [8:0]  sb[N][16];
  int          scnt[N];
  int          mptr;
  int          exp_r[256];
  logic [7:0]  exp_d[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; uart_tx_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    mptr = 0;
  endtask

  // Protocol watchdog: single ack, ack paired with start, one byte in flight.
  logic inflight = 1'b0;
  initial forever begin
    @(negedge clk);
    if (reset) inflight = 1'b0;
    else begin
      if (uart_tx_req || req_ack != '0) begin
        chk("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
        chk("ack_vs_start", 32'(req_ack), uart_tx_req ? (32'd1 << grant_id) : 32'd0);
        chk("one_in_flight", 32'(inflight & uart_tx_req), 32'd0);
        if (uart_tx_req) inflight = 1'b1;
      end
      if (uart_tx_ready) inflight = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic run_vec(input vec_t v, input int k);
    req_valid = v.valid; req_last = '1; req_data = v.data;
    tick();
    chk($sformatf("vec%0d_start", k), 32'(uart_tx_req), 32'd1);
    chk($sformatf("vec%0d_ack", k), 32'(req_ack), 32'd1 << v.exp_g);
    chk($sformatf("vec%0d_grant", k), 32'(grant_id), 32'(v.exp_g));
    chk($sformatf("vec%0d_data", k), 32'(uart_tx_data), 32'(v.exp_d));
    chk($sformatf("vec%0d_busy", k), 32'(busy), 32'd1);
    req_valid = '0;
    tick();
    chk($sformatf("vec%0d_start_once", k), 32'(uart_tx_req), 32'd0);
    chk($sformatf("vec%0d_data_hold", k), 32'(uart_tx_data), 32'(v.exp_d));
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk($sformatf("vec%0d_idle", k), 32'(busy), 32'd0);
  endtask

  // Reference: whole packets served round-robin from the model pointer.
  task automatic run_streams(input string tag, input int budget);
    int mh[N];
    int hd[N];
    bit pend[N];
    int ne = 0, eh = 0, cd = 0, cyc = 0, pick;
    bit busy_model, lastb, done = 0;
    for (int i = 0; i < N; i++) begin mh[i] = 0; hd[i] = 0; pend[i] = 0; end
    busy_model = 1'b1;
    while (busy_model) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && mh[(mptr + k) % N] < scnt[(mptr + k) % N]) pick = (mptr + k) % N;
      if (pick < 0) busy_model = 1'b0;
      else begin
        lastb = 1'b0;
        while (!lastb && mh[pick] < scnt[pick]) begin
          exp_r[ne] = pick;
          exp_d[ne] = sb[pick][mh[pick]][7:0];
          lastb     = sb[pick][mh[pick]][8];
          mh[pick]++;
          ne++;
        end
        mptr = (pick + 1) % N;
      end
    end
    while (!done) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (hd[i] < scnt[i]);
        req_data[8*i +: 8] = req_valid[i] ? sb[i][hd[i]][7:0] : 8'h00;
        req_last[i] = req_valid[i] ? sb[i][hd[i]][8] : 1'b0;
      end
      tick();
      cyc++;
      uart_tx_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) uart_tx_ready = 1'b1;
      end
      if (uart_tx_req) begin
        if (eh < ne) begin
          chk({tag, "_grant"}, 32'(grant_id), 32'(exp_r[eh]));
          chk({tag, "_data"}, 32'(uart_tx_data), 32'(exp_d[eh]));
        end else fail_now({tag, "_extra_start"});
        eh++;
        cd = $urandom_range(1, 4);
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin hd[i]++; pend[i] = 1'b0; end
        if (req_ack[i]) pend[i] = 1'b1;
      end
      done = (eh >= ne) && !busy && (cd == 0);
      for (int i = 0; i < N; i++) if (hd[i] != scnt[i] || pend[i]) done = 1'b0;
      if (cyc > budget) begin
        fail_now({tag, "_cycle_budget"});
        done = 1'b1;
      end
    end
    chk({tag, "_frames"}, 32'(eh), 32'(ne));
    req_valid = '0; req_last = '0; uart_tx_ready = 1'b0;
  endtask

  task automatic gen_random();
    int np, nb;
    for (int i = 0; i < N; i++) begin
      scnt[i] = 0;
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          sb[i][scnt[i]] = {(b == nb - 1), 8'($urandom)};
          scnt[i]++;
        end
      end
    end
  endtask

  initial begin
    vec_t pv;
    tbl[0] = '{4'b0100, 32'h0041_0000, 2, 8'h41};
    tbl[1] = '{4'b1111, 32'h1312_1110, 3, 8'h13};
    tbl[2] = '{4'b1111, 32'h2322_2120, 0, 8'h20};
    tbl[3] = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
    tbl[4] = '{4'b1001, 32'hB300_00B0, 3, 8'hB3};
    tbl[5] = '{4'b0110, 32'h00C2_C100, 1, 8'hC1};
    tbl[6] = '{4'b0011, 32'h0000_D1D0, 0, 8'hD0};
    tbl[7] = '{4'b1000, 32'hE300_0000, 3, 8'hE3};

    do_reset();
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_start", 32'(uart_tx_req), 32'd0);
    chk("rst_data", 32'(uart_tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(released_by_timeout), 32'd0);

    for (int k = 0; k < 8; k++) run_vec(tbl[k], k);

    // Reset while a frame is in flight, with the pointer parked away from 0.
    pv = '{4'b0010, 32'h0000_6100, 1, 8'h61};
    run_vec(pv, 8);
    req_valid = 4'b1000; req_last = 4'b1000; req_data = 32'h7300_0000;
    tick();
    chk("mid_grant", 32'(grant_id), 32'd3);
    req_valid = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_start", 32'(uart_tx_req), 32'd0);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    chk("mid_rst_data", 32'(uart_tx_data), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'h8300_0080;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    chk("post_rst_ack", 32'(req_ack), 32'd1);
    chk("post_rst_data", 32'(uart_tx_data), 32'h80);
    req_valid = '0;
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Packet lock: requester 1 keeps the UART for its whole packet.
    do_reset();
    for (int i = 0; i < N; i++) scnt[i] = 0;
    sb[1][0] = 9'h010; sb[1][1] = 9'h011; sb[1][2] = 9'h112; scnt[1] = 3;
    sb[3][0] = 9'h133; scnt[3] = 1;
    run_streams("lock", 500);

    // Round robin: order 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin sb[i][0] = 9'h1A0 + 9'(i); scnt[i] = 1; end
    sb[0][1] = 9'h1A4; scnt[0] = 2;
    run_streams("rr", 500);

    // Spurious ready in IDLE, then owner goes quiet in HOLD.
    do_reset();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_start", 32'(uart_tx_req), 32'd0);
    req_valid = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_0050;
    tick();
    chk("hold_first_grant", 32'(grant_id), 32'd0);
    chk("hold_first_data", 32'(uart_tx_data), 32'h50);
    req_valid = '0;
    tick();
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("hold_entered", 32'(busy), 32'd1);
    req_valid = 4'b0100; req_last = 4'b0100; req_data = 32'h0052_0000;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) uart_tx_ready = 1'b1;
      tick();
      uart_tx_ready = 1'b0;
      chk("hold_no_ack", 32'(req_ack), 32'd0);
      chk("hold_no_start", 32'(uart_tx_req), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_no_tmo", 32'(released_by_timeout), 32'd0);
    end
`ifdef UART_ARB_HOLD_TIMEOUT_EN
    begin
      int w = 0;
      while (!released_by_timeout && w < 20) begin tick(); w++; end
      chk("tmo_pulse", 32'(released_by_timeout), 32'd1);
      chk("tmo_cycles", 32'(w), 32'd6);
      tick();
      chk("tmo_pulse_once", 32'(released_by_timeout), 32'd0);
      chk("tmo_next_start", 32'(uart_tx_req), 32'd1);
      chk("tmo_next_grant", 32'(grant_id), 32'd2);
      chk("tmo_next_data", 32'(uart_tx_data), 32'h52);
    end
`else
    req_valid = 4'b0101; req_last = 4'b0101; req_data = 32'h0052_0051;
    tick();
    chk("hold_owner_grant", 32'(grant_id), 32'd0);
    chk("hold_owner_data", 32'(uart_tx_data), 32'h51);
    req_valid = 4'b0100;
    tick();
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("release_idle", 32'(busy), 32'd0);
    tick();
    chk("after_release_start", 32'(uart_tx_req), 32'd1);
    chk("after_release_grant", 32'(grant_id), 32'd2);
    chk("after_release_data", 32'(uart_tx_data), 32'h52);
`endif
    req_valid = '0;
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("hold_seq_idle", 32'(busy), 32'd0);

    // Randomized packet streams against the packet-level model.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      gen_random();
      run_streams("rand", 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ byte-stream requesters (console echo, debug dump, status reporter, ...).
- Round-robin arbitration with a packet lock: a granted requester keeps the transmitter until it sends a byte flagged last.
- Drives the UART's tx_req/tx_data pair and consumes its one-cycle tx_ready completion pulse.
- Sits between the requester blocks and the UART, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_TIMEOUT, 65535, cycles a locked grant may idle between bytes before forced release (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte on req_data
req_data  in  8*NUM_REQ  byte from requester i, at bits [8i+7:8i]
req_last  in  NUM_REQ  byte from requester i ends its packet
req_ack  out  NUM_REQ  one-cycle pulse: byte from requester i consumed
uart_tx_req  out  1  one-cycle start pulse to the UART
uart_tx_data  out  8  byte to the UART, stable from the start pulse until completion
uart_tx_ready  in  1  one-cycle UART frame-complete pulse
grant_id  out  clog2(NUM_REQ)  current or last granted requester
busy  out  1  high in every state except IDLE
released_by_timeout  out  1  one-cycle pulse on forced release (optional feature only)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - req_ack=0, uart_tx_req=0, uart_tx_data=8'h00, grant_id=0, busy=0, released_by_timeout=0
  - FSM=IDLE, round-robin pointer=0, lock=0
- Reset mid-frame: everything returns to the reset values immediately; no ack is issued for the aborted byte. The UART shares the same reset.
- States: IDLE, WAIT, HOLD.
- IDLE, when any req_valid is set:
  - Winner = first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - In the same edge, register grant_id, uart_tx_data=req_data[winner] and lock=~req_last[winner].
  - Next cycle: uart_tx_req=1 and req_ack[winner]=1, each for exactly one cycle; state goes to WAIT.
  - Latency is 1 cycle from valid to start/ack.
- WAIT: uart_tx_req=0; waits for uart_tx_ready.
  - If lock=1: go to HOLD.
  - If lock=0: pointer=grant_id+1 (wrap), go to IDLE.
- HOLD: only req_valid[grant_id] is considered; other requesters are ignored.
  - When req_valid[grant_id] is set: capture data/last exactly as in IDLE, then start/ack next cycle and go to WAIT.
- Handshake rules:
  - A requester holds valid/data/last stable until it sees its ack.
  - It may present the next byte from the cycle after ack.
  - Valid still high during the ack cycle is not re-consumed, because the FSM is then in WAIT.
  - Dropping valid before capture is legal: no ack is issued and arbitration re-evaluates.
- Boundary conditions:
  - uart_tx_ready outside WAIT is ignored.
  - At most one req_ack bit is high in any cycle.
  - At most one byte is in flight.
  - No new uart_tx_req is issued until the prior uart_tx_ready has been received.
  - Single requester permanently valid and always last: it is re-granted every time, with 1 idle cycle between frames (the IDLE cycle).
  - Pointer wrap: grant of NUM_REQ-1 sets pointer=0.
  - Back-to-back bytes from a locked requester cost 1 HOLD cycle minimum.

Optional Feature:
UART_ARB_HOLD_TIMEOUT_EN
- Defined:
  - A counter of width clog2(HOLD_TIMEOUT+1) clears on HOLD entry and increments each HOLD cycle while req_valid[grant_id]=0.
  - When it reaches HOLD_TIMEOUT: lock=0, pointer=grant_id+1, state goes to IDLE, and released_by_timeout pulses for one cycle.
- Not defined:
  - No counter; HOLD waits indefinitely.
  - released_by_timeout is tied to 0.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum {IDLE, WAIT, HOLD}
  - BYTE_W=8
  - function rr_pick(mask, pointer) returning the index and a found flag
- Sub-module rr_priority_picker: combinational rotate / priority-encode / un-rotate, parameterised on NUM_REQ. Used by IDLE only.

Test Plan:
- Single byte: req_valid[2]=1, data=8'h41, last=1 → next cycle uart_tx_req=1, uart_tx_data=8'h41, req_ack[2]=1. After the UART frame's tx_ready, busy=0 and pointer=3.
- Round robin: all four valid with last=1, pointer=0 → grant order 0,1,2,3,0; each gets exactly one ack per frame.
- Packet lock: requester 1 sends 8'h10, 8'h11, 8'h12 with last on the third byte, requester 3 valid throughout → three consecutive frames from 1, then grant_id=3.
- Reset mid-frame: assert reset in WAIT → all outputs are at reset values in the same cycle; after release, pending requesters are granted starting at 0.
- Early valid drop: requester 0 drops valid in HOLD → no ack and no uart_tx_req.
  - With UART_ARB_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=16: after 16 cycles released_by_timeout pulses and requester 2 is served next.
- Spurious ready: uart_tx_ready pulse in IDLE and in HOLD → no state change, no ack.
